// File: rtl/dwt_pkg.sv
// dwt_pkg: shared types and width helper for the lifting DWT slice.
// Imported by dwt_lift_core and dwt_lift_1d.
package dwt_pkg;

   typedef enum logic {
      DWT_HAAR     = 1'b0,
      DWT_LEGALL53 = 1'b1
   } dwt_mode_e;

   typedef enum logic [1:0] {
      S_FIRST = 2'd0,
      S_ODD   = 2'd1,
      S_EVEN  = 2'd2
   } dwt_state_e;

   // Two guard bits cover the predict difference range.
   function automatic int dwt_out_w(input int data_w);
      return data_w + 2;
   endfunction

endpackage

// File: rtl/dwt_lift_core.sv
// dwt_lift_core: combinational predict/update for Haar and LeGall 5/3.
// All terms signed, shifts are arithmetic (floor).
module dwt_lift_core
   import dwt_pkg::*;
#(
   parameter int W = 10
) (
   input  logic signed [W-1:0] x_even,
   input  logic signed [W-1:0] x_odd,
   input  logic signed [W-1:0] x_next,
   input  logic signed [W-1:0] h_prev,
   input  dwt_mode_e           mode,
   input  logic                first,
   output logic signed [W-1:0] l,
   output logic signed [W-1:0] h
);

   logic [W+1:0]        w_psum;
   logic [W+1:0]        w_usum;
   logic signed [W-1:0] w_pred;
   logic signed [W-1:0] w_h53;
   logic signed [W-1:0] w_hl;
   logic signed [W-1:0] w_l53;
   logic signed [W-1:0] w_hh;
   logic signed [W-1:0] w_lh;

   assign w_psum = {{2{x_even[W-1]}}, x_even}
                 + {{2{x_next[W-1]}}, x_next};
   assign w_pred = w_psum[W:1];
   assign w_h53  = x_odd - w_pred;

   // Left edge mirrors H[-1] = H[0]; sum kept wide so +2 cannot wrap.
   assign w_hl   = first ? w_h53 : h_prev;
   assign w_usum = {{2{w_hl[W-1]}}, w_hl}
                 + {{2{w_h53[W-1]}}, w_h53}
                 + (W+2)'(2);
   assign w_l53  = x_even + w_usum[W+1:2];

   assign w_hh = x_odd - x_even;
   assign w_lh = x_even + {w_hh[W-1], w_hh[W-1:1]};

   always_comb begin
      l = w_lh;
      h = w_hh;
      unique case (mode)
         DWT_HAAR: begin
            l = w_lh;
            h = w_hh;
         end
         DWT_LEGALL53: begin
            l = w_l53;
            h = w_h53;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/dwt_lift_1d.sv
// dwt_lift_1d: streaming one-level 1-D lifting DWT, valid/ready on both sides.
// Build option DWT_LEVEL_SHIFT_EN: in_data unsigned, DC level shift applied.
module dwt_lift_1d
   import dwt_pkg::*;
#(
   parameter  int DATA_W = 8,
   localparam int OUT_W  = dwt_out_w(DATA_W)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    mode,
   input  logic [DATA_W-1:0]       in_data,
   input  logic                    in_valid,
   input  logic                    in_last,
   output logic                    in_ready,
   output logic signed [OUT_W-1:0] out_l,
   output logic signed [OUT_W-1:0] out_h,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    out_last,
   output logic                    err_len
);

   dwt_state_e r_state;
   dwt_state_e w_next;
   dwt_mode_e  r_mode;

   logic signed [OUT_W-1:0] w_x;
   logic signed [OUT_W-1:0] r_x_even;
   logic signed [OUT_W-1:0] r_x_odd;
   logic signed [OUT_W-1:0] r_h_prev;
   logic signed [OUT_W-1:0] w_c_odd;
   logic signed [OUT_W-1:0] w_c_next;
   logic signed [OUT_W-1:0] w_l;
   logic signed [OUT_W-1:0] w_h;
   logic signed [OUT_W-1:0] r_l;
   logic signed [OUT_W-1:0] r_h;

   logic r_first;
   logic r_valid;
   logic r_last;
   logic r_err;
   logic w_acc;
   logic w_emit;
   logic w_drop;

`ifdef DWT_LEVEL_SHIFT_EN
   assign w_x = {2'b00, in_data} - (OUT_W'(1) << (DATA_W-1));
`else
   assign w_x = {{2{in_data[DATA_W-1]}}, in_data};
`endif

   assign in_ready  = !r_valid || out_ready;
   assign w_acc     = in_valid && in_ready;
   assign out_l     = r_l;
   assign out_h     = r_h;
   assign out_valid = r_valid;
   assign out_last  = r_last;
   assign err_len   = r_err;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_FIRST;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      if (w_acc) begin
         unique case (r_state)
            S_FIRST: w_next = in_last ? S_FIRST : S_ODD;
            S_ODD:   w_next = in_last ? S_FIRST : S_EVEN;
            S_EVEN:  w_next = in_last ? S_FIRST : S_ODD;
            default: w_next = S_FIRST;
         endcase
      end
   end

   // In S_ODD the odd sample is live and the right neighbour is mirrored.
   always_comb begin
      w_emit   = 1'b0;
      w_drop   = 1'b0;
      w_c_odd  = r_x_odd;
      w_c_next = w_x;
      unique case (r_state)
         S_ODD: begin
            w_c_odd  = w_x;
            w_c_next = r_x_even;
            w_emit   = w_acc && (in_last || r_mode == DWT_HAAR);
         end
         S_EVEN: begin
            w_emit = w_acc && !in_last && r_mode == DWT_LEGALL53;
            w_drop = w_acc && in_last;
         end
         default: w_drop = w_acc && in_last;
      endcase
   end

   dwt_lift_core #(
      .W (OUT_W)
   ) u_core (
      .x_even (r_x_even),
      .x_odd  (w_c_odd),
      .x_next (w_c_next),
      .h_prev (r_h_prev),
      .mode   (r_mode),
      .first  (r_first),
      .l      (w_l),
      .h      (w_h)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_mode   <= DWT_HAAR;
         r_x_even <= '0;
         r_x_odd  <= '0;
         r_h_prev <= '0;
         r_first  <= 1'b0;
      end else if (w_acc) begin
         unique case (r_state)
            S_FIRST: begin
               r_mode   <= dwt_mode_e'(mode);
               r_x_even <= w_x;
               r_first  <= 1'b1;
            end
            S_ODD: r_x_odd <= w_x;
            S_EVEN: begin
               r_x_even <= w_x;
               r_h_prev <= w_h;
               r_first  <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_l     <= '0;
         r_h     <= '0;
         r_valid <= 1'b0;
         r_last  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_err <= w_drop;
         if (w_emit) begin
            r_l     <= w_l;
            r_h     <= w_h;
            r_last  <= in_last;
            r_valid <= 1'b1;
         end else if (out_ready) begin
            r_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_dwt_lift_1d.sv
// tb_dwt_lift_1d: directed table plus hand sequences for dwt_lift_1d.
// Sample values are given signed and encoded for the level-shift build.
module tb_dwt_lift_1d;

   logic              clk;
   logic              reset;
   logic              mode;
   logic [7:0]        in_data;
   logic              in_valid;
   logic              in_last;
   logic              in_ready;
   logic signed [9:0] out_l;
   logic signed [9:0] out_h;
   logic              out_valid;
   logic              out_ready;
   logic              out_last;
   logic              err_len;

   int checks;
   int failures;

   typedef struct {
      int m;
      int d;
      int lst;
      int ev;
      int el;
      int eh;
      int elast;
      int eerr;
   } vec_t;

   vec_t tv[$];

   dwt_lift_1d #(
      .DATA_W (8)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .mode      (mode),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .out_l     (out_l),
      .out_h     (out_h),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last),
      .err_len   (err_len)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] enc(input int v);
`ifdef DWT_LEVEL_SHIFT_EN
      return 8'(v + 128);
`else
      return 8'(v);
`endif
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic drive(input int m, input int d, input int l);
      mode     = m[0];
      in_data  = enc(d);
      in_last  = l[0];
      in_valid = 1'b1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic add(input int m, input int d, input int l, input int ev,
                      input int el, input int eh, input int elast,
                      input int eerr);
      vec_t v;
      v.m = m; v.d = d; v.lst = l; v.ev = ev;
      v.el = el; v.eh = eh; v.elast = elast; v.eerr = eerr;
      tv.push_back(v);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b0;
      mode     = 1'b0;
      in_data  = '0;
      in_valid = 1'b0;
      in_last  = 1'b0;
      out_ready = 1'b1;

      // Haar 10,14 and floor case 7,4
      add(0,   10, 0, 0,  0,  0, 0, 0);
      add(0,   14, 1, 1, 12,  4, 1, 0);
      add(0,    7, 0, 0,  0,  0, 0, 0);
      add(0,    4, 1, 1,  5, -3, 1, 0);
      // 5/3 four-sample frame
      add(1,   10, 0, 0,  0,  0, 0, 0);
      add(1,   14, 0, 0,  0,  0, 0, 0);
      add(1,   20, 0, 1, 10, -1, 0, 0);
      add(1,   12, 1, 1, 18, -8, 1, 0);
      // Haar multi-pair frame
      add(0,    1, 0, 0,  0,  0, 0, 0);
      add(0,    2, 0, 1,  1,  1, 0, 0);
      add(0,    3, 0, 0,  0,  0, 0, 0);
      add(0,    5, 1, 1,  4,  2, 1, 0);
      // 5/3 minimum frame, negative start
      add(1,   -4, 0, 0,  0,  0, 0, 0);
      add(1,    6, 1, 1,  1, 10, 1, 0);
      // extremes exercise guard bits
      add(1, -128, 0, 0,  0,  0, 0, 0);
      add(1,  127, 1, 1,  0,255, 1, 0);
      add(0, -128, 0, 0,  0,  0, 0, 0);
      add(0,  127, 1, 1, -1,255, 1, 0);
      // in_last on third sample, then clean frame
      add(0,   10, 0, 0,  0,  0, 0, 0);
      add(0,   14, 0, 1, 12,  4, 0, 0);
      add(0,   20, 1, 0,  0,  0, 0, 1);
      add(0,   10, 0, 0,  0,  0, 0, 0);
      add(0,   14, 1, 1, 12,  4, 1, 0);
      // in_last on a lone first sample
      add(1,   33, 1, 0,  0,  0, 0, 1);
      // 5/3 drop in S_EVEN discards pending pair
      add(1,   10, 0, 0,  0,  0, 0, 0);
      add(1,   14, 0, 0,  0,  0, 0, 0);
      add(1,   20, 0, 1, 10, -1, 0, 0);
      add(1,   12, 0, 0,  0,  0, 0, 0);
      add(1,   30, 1, 0,  0,  0, 0, 1);
      // 5/3 frame 10,14 and mid-frame mode change ignored
      add(1,   10, 0, 0,  0,  0, 0, 0);
      add(1,   14, 1, 1, 12,  4, 1, 0);
      add(0,    7, 0, 0,  0,  0, 0, 0);
      add(1,    4, 1, 1,  5, -3, 1, 0);

      #12;
      chk("rst_valid", out_valid, 0);
      chk("rst_l", out_l, 0);
      chk("rst_h", out_h, 0);
      chk("rst_last", out_last, 0);
      chk("rst_err", err_len, 0);
      chk("rst_ready", in_ready, 1);
      reset = 1'b1;
      step();

      foreach (tv[i]) begin
         drive(tv[i].m, tv[i].d, tv[i].lst);
         step();
         chk($sformatf("v%0d_valid", i), out_valid, tv[i].ev);
         chk($sformatf("v%0d_err", i), err_len, tv[i].eerr);
         if (tv[i].ev != 0) begin
            chk($sformatf("v%0d_l", i), out_l, tv[i].el);
            chk($sformatf("v%0d_h", i), out_h, tv[i].eh);
            chk($sformatf("v%0d_last", i), out_last, tv[i].elast);
         end
      end
      in_valid = 1'b0;
      step();
      chk("idle_valid", out_valid, 0);
      chk("idle_err", err_len, 0);

      // backpressure across two pairs
      drive(1, 10, 0);
      step();
      drive(1, 14, 0);
      step();
      out_ready = 1'b0;
      drive(1, 20, 0);
      step();
      chk("bp_p0_valid", out_valid, 1);
      chk("bp_p0_l", out_l, 10);
      chk("bp_p0_h", out_h, -1);
      drive(1, 12, 1);
      chk("bp_ready_low", in_ready, 0);
      for (int k = 0; k < 3; k++) begin
         step();
         chk($sformatf("bp_hold%0d_valid", k), out_valid, 1);
         chk($sformatf("bp_hold%0d_l", k), out_l, 10);
         chk($sformatf("bp_hold%0d_h", k), out_h, -1);
         chk($sformatf("bp_hold%0d_last", k), out_last, 0);
      end
      out_ready = 1'b1;
      #1;
      chk("bp_ready_back", in_ready, 1);
      step();
      in_valid = 1'b0;
      chk("bp_p1_valid", out_valid, 1);
      chk("bp_p1_l", out_l, 18);
      chk("bp_p1_h", out_h, -8);
      chk("bp_p1_last", out_last, 1);
      step();
      chk("bp_drained", out_valid, 0);

      // asynchronous reset mid 5/3 frame
      drive(1, 10, 0);
      step();
      drive(1, 14, 0);
      step();
      drive(1, 20, 0);
      step();
      in_valid = 1'b0;
      chk("mr_pre_valid", out_valid, 1);
      #2;
      reset = 1'b0;
      #1;
      chk("mr_valid", out_valid, 0);
      chk("mr_l", out_l, 0);
      chk("mr_h", out_h, 0);
      chk("mr_last", out_last, 0);
      chk("mr_ready", in_ready, 1);
      step();
      #2;
      reset = 1'b1;
      step();
      drive(0, 7, 0);
      step();
      chk("mr_f0_valid", out_valid, 0);
      drive(0, 4, 1);
      step();
      in_valid = 1'b0;
      chk("mr_f1_valid", out_valid, 1);
      chk("mr_f1_l", out_l, 5);
      chk("mr_f1_h", out_h, -3);
      chk("mr_f1_last", out_last, 1);
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
